// File: rtl/reg_serial_unload_if.sv
// Handshake bundle for reg_serial_unload: parallel load side and serial stream side.
// The master drives load requests and serial backpressure; the slave is the unloader.
interface reg_serial_unload_if #(
   parameter int WIDTH = 32
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_out;
   logic             ser_last;
   logic             busy;

   modport master (
      output load_valid, load_data, ser_ready,
      input  load_ready, ser_valid, ser_out, ser_last, busy
   );

   modport slave (
      input  load_valid, load_data, ser_ready,
      output load_ready, ser_valid, ser_out, ser_last, busy
   );
endinterface

// File: rtl/reg_serial_unload.sv
// Accepts a parallel word over valid/ready and streams it out one bit per accepted beat.
// Optional trailing even-parity beat is enabled by defining SERIAL_UNLOAD_PARITY_EN.
module reg_serial_unload #(
   parameter int WIDTH     = 32,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic                clk,
   input logic                rst,
   reg_serial_unload_if.slave bus
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam int CW = (WIDTH + 1 > 2) ? $clog2(WIDTH + 1) : 1;

`ifdef SERIAL_UNLOAD_PARITY_EN
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);
`else
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
   logic [CW-1:0]    count_q, count_d;
   logic             loadFire;
   logic             beat;
   logic             lastBeat;
   logic             dataBit;
   logic             serBit;

   assign loadFire = (state_q == IDLE) && bus.load_valid;
   assign beat     = (state_q == SHIFT) && bus.ser_ready;
   assign lastBeat = beat && (count_q == LAST_COUNT);
   assign dataBit  = LSB_FIRST ? shiftReg_q[0] : shiftReg_q[WIDTH-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.load_valid) state_d = SHIFT;
         SHIFT:   if (lastBeat)       state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The counter is held on the final beat so it can never wrap, whatever WIDTH is.
   always_comb begin
      shiftReg_d = shiftReg_q;
      count_d    = count_q;
      if (loadFire) begin
         shiftReg_d = bus.load_data;
         count_d    = '0;
      end else if (beat) begin
         shiftReg_d = LSB_FIRST ? (shiftReg_q >> 1) : (shiftReg_q << 1);
         if (!lastBeat) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shiftReg_q <= '0;
         count_q    <= '0;
      end else begin
         shiftReg_q <= shiftReg_d;
         count_q    <= count_d;
      end
   end

`ifdef SERIAL_UNLOAD_PARITY_EN
   logic parity_q;

   // Parity is taken from the word as loaded, since the shift register drains to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else if (loadFire) begin
         parity_q <= ^bus.load_data;
      end
   end

   assign serBit = (count_q == CW'(WIDTH)) ? parity_q : dataBit;
`else
   assign serBit = dataBit;
`endif

   always_comb begin
      bus.load_ready = 1'b1;
      bus.ser_valid  = 1'b0;
      bus.busy       = 1'b0;
      bus.ser_out    = 1'b0;
      bus.ser_last   = 1'b0;
      if (state_q == SHIFT) begin
         bus.load_ready = 1'b0;
         bus.ser_valid  = 1'b1;
         bus.busy       = 1'b1;
         bus.ser_out    = serBit;
         bus.ser_last   = (count_q == LAST_COUNT);
      end
   end

endmodule

// File: tb/tb_reg_serial_unload.sv
// Self-checking bench for reg_serial_unload: an LSB-first and an MSB-first instance share
// one stimulus stream and are compared every cycle against a queue-based bit model.
module tb_reg_serial_unload;

   localparam int WIDTH = 8;
`ifdef SERIAL_UNLOAD_PARITY_EN
   localparam int NBEATS = WIDTH + 1;
`else
   localparam int NBEATS = WIDTH;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       loadValid = 1'b0;
   logic [7:0] loadData = 8'h00;
   logic       serReady = 1'b0;

   int checks = 0;
   int errors = 0;

   bit expA[$];
   bit expB[$];
   bit capA[$];
   bit capB[$];
   int lastCntA, lastIdxA, lastCntB, lastIdxB;

   reg_serial_unload_if #(.WIDTH(WIDTH)) ifA ();
   reg_serial_unload_if #(.WIDTH(WIDTH)) ifB ();

   assign ifA.load_valid = loadValid;
   assign ifA.load_data  = loadData;
   assign ifA.ser_ready  = serReady;
   assign ifB.load_valid = loadValid;
   assign ifB.load_data  = loadData;
   assign ifB.ser_ready  = serReady;

   reg_serial_unload #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (ifA.slave)
   );

   reg_serial_unload #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (ifB.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic lv, input logic [7:0] d, input logic sr);
      loadValid = lv;
      loadData  = d;
      serReady  = sr;
      @(posedge clk);
      #1;
   endtask

   // Model: a word is the list of bits it will produce; the block is busy while the list is non-empty.
   task automatic pushWord(input logic [7:0] d);
      for (int i = 0; i < WIDTH; i++) begin
         expA.push_back(d[i]);
         expB.push_back(d[WIDTH-1-i]);
      end
`ifdef SERIAL_UNLOAD_PARITY_EN
      expA.push_back(^d);
      expB.push_back(^d);
`endif
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         expA.delete();
         expB.delete();
      end else if (expA.size() != 0) begin
         if (serReady) begin
            void'(expA.pop_front());
            void'(expB.pop_front());
         end
      end else if (loadValid) begin
         pushWord(loadData);
      end
   end

   // Records the bits the consumer actually receives, for the hand-computed word checks.
   always @(posedge clk) begin
      if (rst && serReady && ifA.ser_valid) begin
         if (ifA.ser_last) begin
            lastCntA++;
            lastIdxA = capA.size();
         end
         capA.push_back(ifA.ser_out);
      end
      if (rst && serReady && ifB.ser_valid) begin
         if (ifB.ser_last) begin
            lastCntB++;
            lastIdxB = capB.size();
         end
         capB.push_back(ifB.ser_out);
      end
   end

   task automatic compareOne(input string tag, input logic busy, input logic ready, input logic valid,
                             input logic out, input logic last, input int size, input bit head);
      checkOutput({tag, ".busy"},       int'(busy),  int'(size != 0));
      checkOutput({tag, ".load_ready"}, int'(ready), int'(size == 0));
      checkOutput({tag, ".ser_valid"},  int'(valid), int'(size != 0));
      checkOutput({tag, ".ser_out"},    int'(out),   (size != 0) ? int'(head) : 0);
      checkOutput({tag, ".ser_last"},   int'(last),  int'(size == 1));
   endtask

   always @(negedge clk) begin
      compareOne("A", ifA.busy, ifA.load_ready, ifA.ser_valid, ifA.ser_out, ifA.ser_last,
                 expA.size(), (expA.size() != 0) ? expA[0] : 1'b0);
      compareOne("B", ifB.busy, ifB.load_ready, ifB.ser_valid, ifB.ser_out, ifB.ser_last,
                 expB.size(), (expB.size() != 0) ? expB[0] : 1'b0);
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".A.ready"}, int'(ifA.load_ready), 1);
      checkOutput({tag, ".A.valid"}, int'(ifA.ser_valid), 0);
      checkOutput({tag, ".A.busy"},  int'(ifA.busy), 0);
      checkOutput({tag, ".A.out"},   int'(ifA.ser_out), 0);
      checkOutput({tag, ".A.last"},  int'(ifA.ser_last), 0);
      checkOutput({tag, ".B.valid"}, int'(ifB.ser_valid), 0);
      checkOutput({tag, ".B.busy"},  int'(ifB.busy), 0);
      checkOutput({tag, ".B.ready"}, int'(ifB.load_ready), 1);
   endtask

   // Loads one word, optionally stalls or offers a competing load, and checks the delivered stream.
   task automatic runWord(input string tag, input logic [7:0] d, input int stallLo, input int stallHi,
                          input int intrudeAt, input bit par);
      int         cyc;
      int         nStall;
      logic       sr;
      logic       lv;
      logic [7:0] modelA, modelB, gotA, gotB;
      capA.delete();
      capB.delete();
      lastCntA = 0;
      lastCntB = 0;
      lastIdxA = -1;
      lastIdxB = -1;
      applyStimulus(1'b1, d, 1'b1);
      checkOutput({tag, ".modelSize"}, expA.size(), NBEATS);
      modelA = '0;
      modelB = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < expA.size()) modelA[i] = expA[i];
         if (i < expB.size()) modelB[WIDTH-1-i] = expB[i];
      end
      checkOutput({tag, ".modelWordA"}, int'(modelA), int'(d));
      checkOutput({tag, ".modelWordB"}, int'(modelB), int'(d));
      cyc    = 0;
      nStall = 0;
      while (capA.size() < NBEATS && cyc < 60) begin
         sr = !(cyc >= stallLo && cyc <= stallHi);
         lv = (cyc >= intrudeAt && cyc < intrudeAt + 3);
         if (!sr) nStall++;
         applyStimulus(lv, 8'h00, sr);
         cyc++;
      end
      checkOutput({tag, ".beatsA"}, capA.size(), NBEATS);
      checkOutput({tag, ".beatsB"}, capB.size(), NBEATS);
      checkOutput({tag, ".cycles"}, cyc, NBEATS + nStall);
      gotA = '0;
      gotB = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < capA.size()) gotA[i] = capA[i];
         if (i < capB.size()) gotB[WIDTH-1-i] = capB[i];
      end
      checkOutput({tag, ".wordA"}, int'(gotA), int'(d));
      checkOutput({tag, ".wordB"}, int'(gotB), int'(d));
`ifdef SERIAL_UNLOAD_PARITY_EN
      checkOutput({tag, ".parityA"}, (capA.size() > WIDTH) ? int'(capA[WIDTH]) : -1, int'(par));
      checkOutput({tag, ".parityB"}, (capB.size() > WIDTH) ? int'(capB[WIDTH]) : -1, int'(par));
`endif
      checkOutput({tag, ".lastCntA"}, lastCntA, 1);
      checkOutput({tag, ".lastIdxA"}, lastIdxA, NBEATS - 1);
      checkOutput({tag, ".lastCntB"}, lastCntB, 1);
      checkOutput({tag, ".lastIdxB"}, lastIdxB, NBEATS - 1);
      checkOutput({tag, ".readyAfter"}, int'(ifA.load_ready), 1);
   endtask

   initial begin
      rst = 1'b0;
      #3;
      checkResetOutputs("initRst");
      #9;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 8'h00, 1'b1);

      runWord("wordA5", 8'hA5, 100, 100, 100, 1'b0);
      runWord("stall3C", 8'h3C, 2, 4, 100, 1'b0);
      runWord("busyFF", 8'hFF, 100, 100, 2, 1'b0);

      applyStimulus(1'b1, 8'h81, 1'b1);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      checkResetOutputs("midRst");
      @(posedge clk);
      #3;
      rst = 1'b1;
      runWord("after01", 8'h01, 100, 100, 100, 1'b1);

      for (int i = 0; i < 300; i++) begin
         if (i == 150) begin
            #1;
            rst = 1'b0;
            #1;
            checkOutput("rndRst.valid", int'(ifA.ser_valid), 0);
            checkOutput("rndRst.ready", int'(ifB.load_ready), 1);
            #1;
            rst = 1'b1;
         end
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      repeat (NBEATS + 2) applyStimulus(1'b0, 8'h00, 1'b1);

      runWord("word07", 8'h07, 100, 100, 100, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
